// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - segment types, blank constant and hex glyph table for the scan driver
//
// Segment vectors are active-low, ordered {g,f,e,d,c,b,a} so that bit 0 is segment a.

package ssd_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SSD_BLANK = 7'h7F;

    localparam seg_t SEG_0 = 7'h40;
    localparam seg_t SEG_1 = 7'h79;
    localparam seg_t SEG_2 = 7'h24;
    localparam seg_t SEG_3 = 7'h30;
    localparam seg_t SEG_4 = 7'h19;
    localparam seg_t SEG_5 = 7'h12;
    localparam seg_t SEG_6 = 7'h02;
    localparam seg_t SEG_7 = 7'h78;
    localparam seg_t SEG_8 = 7'h00;
    localparam seg_t SEG_9 = 7'h10;
    localparam seg_t SEG_A = 7'h08;
    localparam seg_t SEG_B = 7'h03;   // lowercase b
    localparam seg_t SEG_C = 7'h46;
    localparam seg_t SEG_D = 7'h21;   // lowercase d
    localparam seg_t SEG_E = 7'h06;
    localparam seg_t SEG_F = 7'h0E;

    function automatic seg_t hex_glyph(input logic [3:0] nibble);
        seg_t g;
        case (nibble)
            4'h0: g = SEG_0;
            4'h1: g = SEG_1;
            4'h2: g = SEG_2;
            4'h3: g = SEG_3;
            4'h4: g = SEG_4;
            4'h5: g = SEG_5;
            4'h6: g = SEG_6;
            4'h7: g = SEG_7;
            4'h8: g = SEG_8;
            4'h9: g = SEG_9;
            4'hA: g = SEG_A;
            4'hB: g = SEG_B;
            4'hC: g = SEG_C;
            4'hD: g = SEG_D;
            4'hE: g = SEG_E;
            default: g = SEG_F;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// rtl/ssd_hex_decoder.sv - combinational nibble to active-low seven-segment decoder
//
// Ports:
//   nibble  in  4  hex digit to show
//   seg_n   out 7  active-low segments {g,f,e,d,c,b,a}

module ssd_hex_decoder
    import ssd_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = hex_glyph(nibble);
    end

endmodule

// File: rtl/ssd_scan_driver.sv
// rtl/ssd_scan_driver.sv - time-multiplexed hex display driver with dead-cycle anti-ghosting
//
// Ports:
//   clk    in  1          system clock, rising edge
//   rst_n  in  1          asynchronous active-low reset
//   value  in  4*DIGITS   hex nibbles, digit 0 rightmost, captured on load
//   load   in  1          one-cycle capture strobe for value and dp_in
//   en     in  1          display enable; 0 blanks anodes, scanning keeps running
//   dp_in  in  DIGITS     decimal points, 1 = lit, captured on load
//   seg_n  out 7          active-low segments {g,f,e,d,c,b,a}
//   dp_n   out 1          active-low decimal point
//   an_n   out DIGITS     active-low anodes, at most one low
//
// Build option: define SSD_LZB_EN to blank leading zero digits (digit 0 and
// digits with a lit decimal point are always shown).

module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    input  logic                  en,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     an_n
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [REFRESH_DIV-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0]    val_q, val_d;
    logic [DIGITS-1:0]      dp_q, dp_d;
    logic [6:0]             seg_q, seg_d;
    logic                   dp_n_q, dp_n_d;
    logic [DIGITS-1:0]      an_q, an_d;

    logic [3:0]             cur_nib;
    logic                   cur_dp;
    logic [6:0]             dec_seg;
    logic                   lzb_blank;
    logic                   lit;

    // Counter, index and shadow registers. The index steps on the last
    // cycle of a slot so the next slot starts with cnt == 0 (dead cycle).
    always_comb begin
        cnt_d = cnt_q + REFRESH_DIV'(1);
        idx_d = idx_q;
        if (&cnt_q) begin
            if (idx_q == IDX_W'(DIGITS - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
        val_d = load ? value : val_q;
        dp_d  = load ? dp_in : dp_q;
    end

    // Digit select mux; a loop keeps non-power-of-two DIGITS in range.
    always_comb begin
        cur_nib = 4'h0;
        cur_dp  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib = val_q[4*i +: 4];
                cur_dp  = dp_q[i];
            end
        end
    end

    ssd_hex_decoder u_dec (
        .nibble (cur_nib),
        .seg_n  (dec_seg)
    );

`ifdef SSD_LZB_EN
    // zero_from[i] is set when nibble i and every nibble above it are zero.
    logic [DIGITS-1:0] zero_from;
    logic              zero_acc;
    logic              zero_sel;

    always_comb begin
        zero_from = '0;
        zero_acc  = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_acc     = zero_acc & (val_q[4*i +: 4] == 4'h0);
            zero_from[i] = zero_acc;
        end
        zero_sel = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                zero_sel = zero_from[i];
            end
        end
    end

    assign lzb_blank = (idx_q != '0) && zero_sel && !cur_dp;
`else
    assign lzb_blank = 1'b0;
`endif

    // Output register inputs; anything not lit is fully blanked so the
    // segment lines never carry a glyph while the anodes are off.
    assign lit = en && (cnt_q != '0) && !lzb_blank;

    always_comb begin
        an_d   = '1;
        seg_d  = SSD_BLANK;
        dp_n_d = 1'b1;
        if (lit) begin
            an_d   = ~(DIGITS'(1) << idx_q);
            seg_d  = dec_seg;
            dp_n_d = ~cur_dp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            val_q  <= '0;
            dp_q   <= '0;
            seg_q  <= SSD_BLANK;
            dp_n_q <= 1'b1;
            an_q   <= '1;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            val_q  <= val_d;
            dp_q   <= dp_d;
            seg_q  <= seg_d;
            dp_n_q <= dp_n_d;
            an_q   <= an_d;
        end
    end

    assign seg_n = seg_q;
    assign dp_n  = dp_n_q;
    assign an_n  = an_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb/tb_ssd_scan_driver.sv - directed self-checking bench for ssd_scan_driver (DIGITS=4, REFRESH_DIV=2)

module tb_ssd_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value = 16'h0000;
    logic        load = 1'b0;
    logic        en = 1'b1;
    logic [3:0]  dp_in = 4'b0000;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;

    int checks = 0;
    int errors = 0;
    int k = 0;      // rising edges since reset release

    ssd_scan_driver #(.DIGITS(4), .REFRESH_DIV(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .value (value),
        .load  (load),
        .en    (en),
        .dp_in (dp_in),
        .seg_n (seg_n),
        .dp_n  (dp_n),
        .an_n  (an_n)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        k++;
    endtask

    // Outputs after edge k show the state left by edge k-1 (4-cycle slots).
    function automatic int cur_digit();
        return ((k - 1) / 4) % 4;
    endfunction

    function automatic bit cur_dead();
        return ((k - 1) % 4) == 0;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (an_n !== 4'hF) begin errors++; $display("FAIL reset_an: got %h want F", an_n); end
        checks++; if (seg_n !== 7'h7F) begin errors++; $display("FAIL reset_seg: got %h want 7F", seg_n); end
        checks++; if (dp_n !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b want 1", dp_n); end
    endtask

    task automatic test_scan();
        logic [3:0] exp_an [17];
        exp_an = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hF,
                   4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7, 4'hF};
        rst_n = 1'b1;
        k = 0;
        for (int c = 0; c < 17; c++) begin
            tick();
            checks++;
            if (an_n !== exp_an[c]) begin errors++; $display("FAIL scan_an[%0d]: got %h want %h", c, an_n, exp_an[c]); end
            if (exp_an[c] != 4'hF) begin
                checks++;
                if (seg_n !== 7'h40) begin errors++; $display("FAIL scan_seg[%0d]: got %h want 40", c, seg_n); end
            end else begin
                checks++;
                if (seg_n !== 7'h7F) begin errors++; $display("FAIL scan_dead_seg[%0d]: got %h want 7F", c, seg_n); end
            end
        end
    endtask

    task automatic test_load_value();
        logic [6:0] glyph [4];
        logic [3:0] ea;
        logic [6:0] es;
        int d;
        glyph = '{7'h0E, 7'h08, 7'h00, 7'h79};
        value = 16'h18AF;
        dp_in = 4'b0000;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        value = 16'h0000;
        for (int c = 0; c < 16; c++) begin
            tick();
            d = cur_digit();
            if (cur_dead()) begin ea = 4'hF; es = 7'h7F; end
            else begin ea = ~(4'b0001 << d); es = glyph[d]; end
            checks++;
            if (an_n !== ea) begin errors++; $display("FAIL load_an k=%0d: got %h want %h", k, an_n, ea); end
            checks++;
            if (seg_n !== es) begin errors++; $display("FAIL load_seg k=%0d: got %h want %h", k, seg_n, es); end
            checks++;
            if (dp_n !== 1'b1) begin errors++; $display("FAIL load_dp k=%0d: got %b want 1", k, dp_n); end
        end
    endtask

    task automatic test_load_at_advance();
        logic [6:0] glyph [4];
        int d;
        glyph = '{7'h12, 7'h19, 7'h30, 7'h24};
        while (((k + 1) % 4) != 0) tick();
        value = 16'h2345;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        tick();
        checks++;
        if (an_n !== 4'hF) begin errors++; $display("FAIL adv_dead_an: got %h want F", an_n); end
        tick();
        d = cur_digit();
        checks++;
        if (an_n !== ~(4'b0001 << d)) begin errors++; $display("FAIL adv_an: got %h want %h", an_n, ~(4'b0001 << d)); end
        checks++;
        if (seg_n !== glyph[d]) begin errors++; $display("FAIL adv_seg: got %h want %h", seg_n, glyph[d]); end
    endtask

    task automatic test_enable();
        int d;
        while (((k - 1) % 4) != 1) tick();
        en = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (an_n !== 4'hF) begin errors++; $display("FAIL en_off_an[%0d]: got %h want F", c, an_n); end
            checks++;
            if (seg_n !== 7'h7F) begin errors++; $display("FAIL en_off_seg[%0d]: got %h want 7F", c, seg_n); end
        end
        en = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            d = cur_digit();
            checks++;
            if (cur_dead()) begin
                if (an_n !== 4'hF) begin errors++; $display("FAIL en_on_an k=%0d: got %h want F", k, an_n); end
            end else begin
                if (an_n !== ~(4'b0001 << d)) begin errors++; $display("FAIL en_on_an k=%0d: got %h want %h", k, an_n, ~(4'b0001 << d)); end
            end
        end
    endtask

    task automatic test_lzb();
        logic [6:0] glyph [4];
        logic [3:0] blank;
        logic [3:0] ea;
        logic [6:0] es;
        logic       ed;
        int d;
        glyph = '{7'h40, 7'h12, 7'h40, 7'h40};
`ifdef SSD_LZB_EN
        blank = 4'b0100;
`else
        blank = 4'b0000;
`endif
        value = 16'h0050;
        dp_in = 4'b1000;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        dp_in = 4'b0000;
        for (int c = 0; c < 16; c++) begin
            tick();
            d = cur_digit();
            if (cur_dead() || blank[d]) begin ea = 4'hF; es = 7'h7F; ed = 1'b1; end
            else begin ea = ~(4'b0001 << d); es = glyph[d]; ed = (d != 3); end
            checks++;
            if (an_n !== ea) begin errors++; $display("FAIL lzb_an k=%0d: got %h want %h", k, an_n, ea); end
            checks++;
            if (seg_n !== es) begin errors++; $display("FAIL lzb_seg k=%0d: got %h want %h", k, seg_n, es); end
            checks++;
            if (dp_n !== ed) begin errors++; $display("FAIL lzb_dp k=%0d: got %b want %b", k, dp_n, ed); end
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] blank;
        logic [3:0] ea;
        logic [6:0] es;
        int d;
`ifdef SSD_LZB_EN
        blank = 4'b1110;
`else
        blank = 4'b0000;
`endif
        while (!(cur_digit() == 0 && ((k - 1) % 4) == 2)) tick();
        checks++;
        if (an_n !== 4'hE) begin errors++; $display("FAIL pre_rst_an: got %h want E", an_n); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (an_n !== 4'hF) begin errors++; $display("FAIL async_rst_an: got %h want F", an_n); end
        checks++; if (seg_n !== 7'h7F) begin errors++; $display("FAIL async_rst_seg: got %h want 7F", seg_n); end
        checks++; if (dp_n !== 1'b1) begin errors++; $display("FAIL async_rst_dp: got %b want 1", dp_n); end
        @(negedge clk);
        value = 16'hFFFF;
        rst_n = 1'b1;
        k = 0;
        for (int c = 0; c < 16; c++) begin
            tick();
            d = cur_digit();
            if (cur_dead() || blank[d]) begin ea = 4'hF; es = 7'h7F; end
            else begin ea = ~(4'b0001 << d); es = 7'h40; end
            checks++;
            if (an_n !== ea) begin errors++; $display("FAIL post_rst_an k=%0d: got %h want %h", k, an_n, ea); end
            checks++;
            if (seg_n !== es) begin errors++; $display("FAIL post_rst_seg k=%0d: got %h want %h", k, seg_n, es); end
            checks++;
            if (dp_n !== 1'b1) begin errors++; $display("FAIL post_rst_dp k=%0d: got %b want 1", k, dp_n); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load_value();
        test_load_at_advance();
        test_enable();
        test_lzb();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
